// File: rtl/game_pkg.sv
// Shared constants for the game-flow controller and its score accumulator.
// State encoding, widths, default level targets and the time-bonus multiplier.
package game_pkg;

    localparam int SCORE_W = 16;
    localparam int ADD_W   = 12;
    localparam int LEVEL_W = 3;

    localparam int              MAX_LEVEL_DEF   = 5;
    localparam logic [15:0]     TARGET_BASE_DEF = 16'd650;
    localparam logic [15:0]     TARGET_STEP_DEF = 16'd550;
    localparam int              TIME_BONUS_MUL  = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;
    localparam logic [2:0] ST_WIN   = 3'd6;

    // Target for a level: base + (level-1)*step, wrapping at 16 bits.
    function automatic logic [SCORE_W-1:0] level_target(
        input logic [LEVEL_W-1:0] lvl,
        input logic [SCORE_W-1:0] base,
        input logic [SCORE_W-1:0] step
    );
        logic [SCORE_W-1:0] idx;
        idx = SCORE_W'(lvl) - 16'd1;
        return base + idx * step;
    endfunction

endpackage

// File: rtl/level_ctrl_score_accum.sv
// Saturating score accumulator: adds a grabbed-object value and/or a
// time bonus each cycle, clamps at all-ones and never wraps.
module score_accum
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               add_en,
    input  logic [ADD_W-1:0]   add_val,
    input  logic               bonus_en,
    input  logic [SCORE_W-1:0] bonus_val,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W+1:0] sum;
    logic [SCORE_W+1:0] add_ext;
    logic [SCORE_W+1:0] bonus_ext;

    // Widened sum, then clamp to the maximum score on overflow.
    always_comb begin
        add_ext   = add_en ? (SCORE_W+2)'(add_val) : '0;
        bonus_ext = bonus_en ? {2'b00, bonus_val} : '0;
        sum       = {2'b00, score_q} + add_ext + bonus_ext;
        score_d   = score_q;
        if (clear) begin
            score_d = '0;
        end else if (|sum[SCORE_W+1:SCORE_W]) begin
            score_d = '1;
        end else begin
            score_d = sum[SCORE_W-1:0];
        end
    end

    // Score register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/level_ctrl.sv
// Game-flow controller downstream of the round timer (level/score/result).
// Optional macro EARLY_CLEAR_EN: early level end on target plus time bonus.
module level_ctrl
    import game_pkg::*;
#(
    parameter int          MAX_LEVEL   = MAX_LEVEL_DEF,
    parameter logic [15:0] TARGET_BASE = TARGET_BASE_DEF,
    parameter logic [15:0] TARGET_STEP = TARGET_STEP_DEF
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                pause,
    input  logic                score_add,
    input  logic [ADD_W-1:0]    score_to_add,
    input  logic [7:0]          time_remain,
    input  logic                time_up,
    output logic                timer_enable,
    output logic                time_resetn,
    output logic                move_enable,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  target_score,
    output logic [LEVEL_W-1:0]  level,
    output logic                level_clear,
    output logic                game_over,
    output logic                game_win
);

    logic [2:0]         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               te_q, te_d;
    logic               tr_q, tr_d;
    logic               me_q, me_d;

    logic [SCORE_W-1:0] score_w;
    logic [SCORE_W-1:0] target_w;
    logic [SCORE_W-1:0] bonus_w;
    logic [SCORE_W:0]   judged_w;
    logic               acc_clear;
    logic               acc_add;
    logic               acc_bonus;
    logic               early_w;
    logic               pass_w;
    logic               last_level_w;

    assign target_w     = level_target(level_q, TARGET_BASE, TARGET_STEP);
    assign bonus_w      = SCORE_W'(time_remain) * SCORE_W'(TIME_BONUS_MUL);
    assign last_level_w = (level_q == LEVEL_W'(MAX_LEVEL));

`ifdef EARLY_CLEAR_EN
    assign acc_bonus = (state_q == ST_CHECK);
    assign early_w   = (score_w >= target_w);
`else
    assign acc_bonus = 1'b0;
    assign early_w   = 1'b0;
`endif

    // The CHECK decision sees the score including any bonus credited now.
    assign judged_w = {1'b0, score_w} + (acc_bonus ? {1'b0, bonus_w} : '0);
    assign pass_w   = (judged_w >= {1'b0, target_w});

    // Next-state, level and score-control decode.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    level_d   = LEVEL_W'(1);
                    acc_clear = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_PLAY;
            ST_PLAY: begin
                acc_add = score_add;
                if (time_up || early_w) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pass_w) begin
                    state_d = last_level_w ? ST_WIN : ST_CLEAR;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_CLEAR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    level_d = level_q + LEVEL_W'(1);
                end
            end
            ST_OVER, ST_WIN: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    level_d   = LEVEL_W'(1);
                    acc_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer and motion controls are registered from the upcoming state.
    always_comb begin
        te_d = (state_d == ST_PLAY) && !pause;
        me_d = (state_d == ST_PLAY) && !pause;
        tr_d = !((state_d == ST_IDLE) || (state_d == ST_LOAD));
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            level_q <= LEVEL_W'(1);
            te_q    <= 1'b0;
            tr_q    <= 1'b0;
            me_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            te_q    <= te_d;
            tr_q    <= tr_d;
            me_q    <= me_d;
        end
    end

    score_accum u_score (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (acc_clear),
        .add_en    (acc_add),
        .add_val   (score_to_add),
        .bonus_en  (acc_bonus),
        .bonus_val (bonus_w),
        .score     (score_w)
    );

    assign timer_enable = te_q;
    assign time_resetn  = tr_q;
    assign move_enable  = me_q;
    assign score        = score_w;
    assign target_score = target_w;
    assign level        = level_q;
    assign level_clear  = (state_q == ST_CLEAR);
    assign game_over    = (state_q == ST_OVER);
    assign game_win     = (state_q == ST_WIN);

endmodule
